seq_arith_unit: RTL and testbench
=================================

# seq_arith_unit

Parametrised, handshaked successor to the single-cycle arithmetic unit in the ALU datapath. It performs unsigned add, subtract, multiply and divide on DATA_WIDTH operands. Add, subtract and multiply complete in one cycle. Divide is iterative, producing one quotient bit per cycle. Operands enter through a valid/ready port; the result, the second result word and status flags leave through a valid/ready port. The unit sits between the ALU decode stage and the ALU output mux.

## Interface
- DATA_WIDTH, 16, operand and result width; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  unit can accept an operation.
- in1  in  DATA_WIDTH  operand A (dividend).
- in2  in  DATA_WIDTH  operand B (divisor).
- arith_fun  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- arith_out  out  DATA_WIDTH  primary result: sum, difference, product low half, or quotient.
- arith_out_hi  out  DATA_WIDTH  product high half for mul, remainder for div, zero otherwise.
- arith_cout  out  1  carry out for add, borrow (in1 < in2) for sub, zero otherwise.
- arith_ovf  out  1  signed overflow for add/sub; product high half nonzero for mul; zero for div.
- arith_zero  out  1  arith_out == 0.
- div_by_zero  out  1  div issued with in2 == 0.

## Operation
- FSM states: IDLE, DIV, DONE.
- in_ready = (state == IDLE).
- Accept occurs on a clock edge with in_valid && in_ready. At accept, the opcode and operands are latched; the input pins are don't-care afterwards.
- IDLE, accept of add/sub/mul: compute combinationally from the inputs, register all outputs, go to DONE.
- IDLE, accept of div with in2 == 0:
  - arith_out = all ones, arith_out_hi = in1, div_by_zero = 1.
  - Go directly to DONE with no iterations.
- IDLE, accept of div with in2 != 0:
  - Load the divider; iteration counter = DATA_WIDTH-1; go to DIV.
- DIV: one restoring step per cycle, MSB first.
  - Shift the partial remainder left by 1 and bring in the next dividend bit.
  - If remainder >= divisor: subtract the divisor and set quotient bit 1.
  - When the step with counter == 0 completes, register the quotient and remainder and go to DONE.
- DONE: out_valid = 1; all result and flag outputs are held stable. When out_valid && out_ready, go to IDLE.
- Arithmetic rules:
  - Add: {arith_cout, arith_out} = in1 + in2, computed at DATA_WIDTH+1 bits.
  - Sub: arith_out = in1 - in2 modulo 2^DATA_WIDTH.
  - Mul: {arith_out_hi, arith_out} = in1 * in2, full 2*DATA_WIDTH-bit product.
  - Flags that do not apply to the current opcode read 0.
- Reset: in any state, including mid-division, rst returns the FSM to IDLE and discards the in-flight operation.

## Timing
- Reset values: out_valid 0, all result and flag outputs 0, state IDLE. in_ready reads 1 in the cycle after rst deasserts.
- Accept at edge T (add/sub/mul/div-by-zero): out_valid = 1 from T+1.
- Accept at edge T (div, in2 != 0): DIV occupies cycles T+1..T+DATA_WIDTH; out_valid = 1 from T+DATA_WIDTH+1.
- Outputs change only on the edge that enters DONE; they hold through backpressure.
- If out_ready is already high when DONE is entered, the result is consumed on the next edge. in_ready rises the cycle after consumption.
- Peak throughput: one add/sub/mul every 2 cycles; one divide every DATA_WIDTH+2 cycles.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid decode only from state.

## Structure
- Shared package arith_pkg:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the FSM state enum (IDLE, DIV, DONE).
- Sub-module seq_divider, parametrised by DATA_WIDTH.
  - Ports: clk, rst, start, dividend, divisor, busy, done, quotient, remainder.
  - Holds the iterative restoring datapath and its counter.
- seq_arith_unit owns the FSM, the single-cycle datapath, flag generation and output registers.

## Test plan
- Add, DATA_WIDTH=16: in1=0xFFFF, in2=0x0001 -> arith_out=0x0000, arith_cout=1, arith_zero=1, arith_ovf=0, out_valid one cycle after accept.
- Sub: in1=0x8000, in2=0x0001 -> arith_out=0x7FFF, arith_cout=0, arith_ovf=1. Then in1=3, in2=5 -> arith_out=0xFFFE, arith_cout=1.
- Mul: in1=0x1234, in2=0x0100 -> arith_out_hi=0x0012, arith_out=0x3400, arith_ovf=1.
- Div: in1=1000, in2=7 -> arith_out=142, arith_out_hi=6; out_valid exactly 17 cycles after accept; in_ready low throughout.
- Div by zero: in1=0x00AB, in2=0 -> arith_out=0xFFFF, arith_out_hi=0x00AB, div_by_zero=1, out_valid one cycle after accept.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; in_valid pulses in that window are not accepted.
  - Assert rst at DIV cycle 8 -> next cycle state IDLE, all outputs 0, in_ready=1; a following add completes normally.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - opcodes and FSM state type shared by the sequential arithmetic unit
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per cycle, MSB first
module seq_divider #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [DATA_WIDTH-1:0] dvd_q, dvs_q, rem_q, quo_q;
    logic [CW-1:0]         cnt_q;
    logic                  busy_q;

    logic [DATA_WIDTH:0]   shifted;
    logic                  ge;
    logic [DATA_WIDTH-1:0] rem_next, quo_next;

    // The shifted remainder needs one extra bit; the difference fits in DATA_WIDTH
    // bits whenever it is actually taken, so modular subtraction is enough.
    always_comb begin
        shifted  = {rem_q, dvd_q[DATA_WIDTH-1]};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_next = ge ? (shifted[DATA_WIDTH-1:0] - dvs_q) : shifted[DATA_WIDTH-1:0];
        quo_next = {quo_q[DATA_WIDTH-2:0], ge};
    end

    // Results are presented on the final step so the owner can register them on that edge.
    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == '0);
    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= CNT_LAST;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            dvd_q <= {dvd_q[DATA_WIDTH-2:0], 1'b0};
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// rtl/seq_arith_unit.sv - handshaked add/sub/mul/div unit with registered result and flags
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [1:0]            arith_fun,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] arith_out,
    output logic [DATA_WIDTH-1:0] arith_out_hi,
    output logic                  arith_cout,
    output logic                  arith_ovf,
    output logic                  arith_zero,
    output logic                  div_by_zero
);

    localparam int W = DATA_WIDTH;

    state_t state, state_next;

    logic         div_start, div_busy, div_done;
    logic [W-1:0] div_q, div_r;

    logic [W:0]     sum;
    logic [W-1:0]   diff;
    logic [2*W-1:0] prod;

    logic         load;
    logic [W-1:0] n_lo, n_hi;
    logic         n_cout, n_ovf, n_dbz;

    seq_divider #(.DATA_WIDTH(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (in1),
        .divisor   (in2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        sum  = {1'b0, in1} + {1'b0, in2};
        diff = in1 - in2;
        prod = {{W{1'b0}}, in1} * {{W{1'b0}}, in2};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        load       = 1'b0;
        n_lo       = '0;
        n_hi       = '0;
        n_cout     = 1'b0;
        n_ovf      = 1'b0;
        n_dbz      = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = DONE;
                    unique case (arith_fun)
                        OP_ADD: begin
                            n_lo   = sum[W-1:0];
                            n_cout = sum[W];
                            n_ovf  = (in1[W-1] == in2[W-1]) && (sum[W-1] != in1[W-1]);
                        end
                        OP_SUB: begin
                            n_lo   = diff;
                            n_cout = (in1 < in2);
                            n_ovf  = (in1[W-1] != in2[W-1]) && (diff[W-1] != in1[W-1]);
                        end
                        OP_MUL: begin
                            n_lo  = prod[W-1:0];
                            n_hi  = prod[2*W-1:W];
                            n_ovf = |prod[2*W-1:W];
                        end
                        default: begin
                            if (in2 == '0) begin
                                n_lo  = '1;
                                n_hi  = in1;
                                n_dbz = 1'b1;
                            end else begin
                                load       = 1'b0;
                                div_start  = 1'b1;
                                state_next = DIV;
                            end
                        end
                    endcase
                end
            end
            DIV: begin
                // An idle divider here means the operation was lost; recover rather than hang.
                if (!div_busy) begin
                    state_next = IDLE;
                end else if (div_done) begin
                    load       = 1'b1;
                    n_lo       = div_q;
                    n_hi       = div_r;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arith_out    <= '0;
            arith_out_hi <= '0;
            arith_cout   <= 1'b0;
            arith_ovf    <= 1'b0;
            arith_zero   <= 1'b0;
            div_by_zero  <= 1'b0;
        end else if (load) begin
            arith_out    <= n_lo;
            arith_out_hi <= n_hi;
            arith_cout   <= n_cout;
            arith_ovf    <= n_ovf;
            arith_zero   <= (n_lo == '0);
            div_by_zero  <= n_dbz;
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb/tb_seq_arith_unit.sv - self-checking bench for seq_arith_unit at DATA_WIDTH=16
module tb_seq_arith_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [1:0]  arith_fun;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] arith_out;
    logic [15:0] arith_out_hi;
    logic        arith_cout;
    logic        arith_ovf;
    logic        arith_zero;
    logic        div_by_zero;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    seq_arith_unit #(.DATA_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in1          (in1),
        .in2          (in2),
        .arith_fun    (arith_fun),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .arith_out    (arith_out),
        .arith_out_hi (arith_out_hi),
        .arith_cout   (arith_cout),
        .arith_ovf    (arith_ovf),
        .arith_zero   (arith_zero),
        .div_by_zero  (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] lo, input logic [15:0] hi, input logic cout,
                                input logic ovf, input logic zero, input logic dbz, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
        v.cout = cout; v.ovf = ovf; v.zero = zero; v.dbz = dbz; v.lat = lat;
        return v;
    endfunction

    // Independent reference using integer arithmetic and range tests for overflow.
    function automatic vec_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        vec_t   v;
        int     sa, sb_, r;
        longint p;
        v = mk(op, a, b, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        sa  = int'($signed(a));
        sb_ = int'($signed(b));
        case (op)
            2'b00: begin
                r      = int'(a) + int'(b);
                v.lo   = 16'(r);
                v.cout = (r > 65535);
                v.ovf  = ((sa + sb_) > 32767) || ((sa + sb_) < -32768);
            end
            2'b01: begin
                r      = int'(a) - int'(b);
                v.lo   = 16'(r);
                v.cout = (a < b);
                v.ovf  = ((sa - sb_) > 32767) || ((sa - sb_) < -32768);
            end
            2'b10: begin
                p     = longint'(a) * longint'(b);
                v.lo  = 16'(p);
                v.hi  = 16'(p >> 16);
                v.ovf = (v.hi != 16'h0);
            end
            default: begin
                if (b == 16'h0) begin
                    v.lo  = 16'hFFFF;
                    v.hi  = a;
                    v.dbz = 1'b1;
                end else begin
                    v.lo  = a / b;
                    v.hi  = a % b;
                    v.lat = 17;
                end
            end
        endcase
        v.zero = (v.lo == 16'h0);
        return v;
    endfunction

    task automatic compare_out(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got output with no expected entry, required one pending", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_out"},   arith_out,    e.lo);
            check({tag, "_hi"},    arith_out_hi, e.hi);
            check({tag, "_cout"},  arith_cout,   e.cout);
            check({tag, "_ovf"},   arith_ovf,    e.ovf);
            check({tag, "_zero"},  arith_zero,   e.zero);
            check({tag, "_dbz"},   div_by_zero,  e.dbz);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", in_ready, 1'b1);
    endtask

    task automatic drive_accept(input vec_t v);
        in_valid  = 1'b1;
        arith_fun = v.op;
        in1       = v.a;
        in2       = v.b;
        @(posedge clk); #1;
        sb.push_back(v);
        in_valid  = 1'b0;
        in1       = 16'($urandom);
        in2       = 16'($urandom);
        arith_fun = 2'($urandom);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int   lat;
        logic ready_seen;
        wait_ready();
        drive_accept(v);
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        check({tag, "_in_ready_busy"}, {in_ready, ready_seen}, 2'b00);
        if (out_valid) compare_out(tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ready_after"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        logic [15:0] held;
        vec_t v;

        vecs[0]  = mk(2'b00, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        vecs[1]  = mk(2'b01, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        vecs[2]  = mk(2'b01, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        vecs[3]  = mk(2'b10, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        vecs[4]  = mk(2'b11, 16'd1000, 16'd7,    16'd142,  16'd6,    1'b0, 1'b0, 1'b0, 1'b0, 17);
        vecs[5]  = mk(2'b11, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        vecs[6]  = mk(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        vecs[7]  = mk(2'b10, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        vecs[8]  = mk(2'b11, 16'd5,    16'd10,   16'd0,    16'd5,    1'b0, 1'b0, 1'b1, 1'b0, 17);
        vecs[9]  = mk(2'b01, 16'd5,    16'd5,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 1);
        vecs[10] = mk(2'b11, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 17);
        vecs[11] = mk(2'b10, 16'd3,    16'd4,    16'd12,   16'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in1 = 16'h0; in2 = 16'h0; arith_fun = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_flags", {in_ready, out_valid, arith_cout, arith_ovf, arith_zero, div_by_zero}, 6'b100000);
        check("reset_out", {arith_out_hi, arith_out}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = (i % 6 == 5) ? 16'h0 : 16'($urandom_range(0, 300));
            run_op(model(2'(i % 4), ra, rb), $sformatf("rnd%0d", i));
        end

        // Backpressure: result must hold and in_valid pulses must be ignored.
        wait_ready();
        drive_accept(model(2'b00, 16'h0102, 16'h0304));
        held = arith_out;
        check("bp_first", held, 16'h0406);
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            arith_fun = 2'b10;
            in1       = 16'($urandom);
            in2       = 16'($urandom);
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", c), {out_valid, in_ready, arith_out}, {2'b10, held});
        end
        in_valid = 1'b0;
        compare_out("bp");
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {in_ready, out_valid}, 2'b10);
        run_op(model(2'b01, 16'h0010, 16'h0001), "bp_next");

        // Reset in the middle of a division discards it.
        wait_ready();
        drive_accept(model(2'b11, 16'd1000, 16'd7));
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("mid_div_busy", {in_ready, out_valid}, 2'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_front());
        check("rst_div_flags", {in_ready, out_valid, arith_cout, arith_ovf, arith_zero, div_by_zero}, 6'b100000);
        check("rst_div_out", {arith_out_hi, arith_out}, 32'h0);
        run_op(model(2'b00, 16'h1111, 16'h2222), "post_rst");
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
